// File: rtl/rr_decode_arbiter.sv
// Four-way round-robin arbiter with a decoded one-hot grant, owner release,
// hold timeout and a mandatory dead cycle between successive owners.
module rr_decode_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LIMIT = CW'(HOLD_MAX);

  state_t        state, state_next;
  logic [1:0]    ptr, ptr_next;
  logic [CW-1:0] hold_cnt, hold_cnt_next;
  logic [3:0]    grant_next;
  logic [1:0]    grant_idx_next;
  logic          grant_valid_next;
  logic          timeout_next;

  logic          found;
  logic [1:0]    winner;
  logic [1:0]    cand;
  logic          release_now;
  logic          expire_now;

  // Rotating priority search: the first set request at or after ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign release_now = done[grant_idx] | ~req[grant_idx];
  assign expire_now  = (hold_cnt == HOLD_LIMIT);

  always_comb begin
    state_next       = state;
    ptr_next         = ptr;
    hold_cnt_next    = hold_cnt;
    grant_next       = grant;
    grant_idx_next   = grant_idx;
    grant_valid_next = grant_valid;
    timeout_next     = 1'b0;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_next       = GRANT;
          grant_idx_next   = winner;
          grant_next       = 4'b0001 << winner;
          grant_valid_next = 1'b1;
          hold_cnt_next    = CW'(1);
        end
      end

      GRANT: begin
        if (release_now || expire_now) begin
          // A release in the timeout cycle wins, so no timeout pulse then.
          state_next       = GAP;
          grant_next       = 4'b0000;
          grant_valid_next = 1'b0;
          ptr_next         = grant_idx + 2'd1;
          hold_cnt_next    = '0;
          timeout_next     = ~release_now;
        end else if (hold_cnt != HOLD_LIMIT) begin
          hold_cnt_next = hold_cnt + CW'(1);
        end
      end

      GAP: begin
        state_next = IDLE;
      end

      default: begin
        state_next       = IDLE;
        grant_next       = 4'b0000;
        grant_valid_next = 1'b0;
        hold_cnt_next    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      hold_cnt    <= '0;
      grant       <= 4'b0000;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      hold_cnt    <= hold_cnt_next;
      grant       <= grant_next;
      grant_idx   <= grant_idx_next;
      grant_valid <= grant_valid_next;
      timeout     <= timeout_next;
    end
  end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench for rr_decode_arbiter: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_rr_decode_arbiter;

  localparam int HOLD_MAX = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] done = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Behavioural model: owner, rotation pointer, cycles held so far.
  bit m_busy;
  bit m_gap;
  bit m_timeout;
  int m_ptr;
  int m_owner;
  int m_cnt;

  rr_decode_arbiter #(.HOLD_MAX(HOLD_MAX), .CW(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .done(done),
    .grant(grant),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic resetModel();
    m_busy = 0; m_gap = 0; m_timeout = 0;
    m_ptr = 0; m_owner = 0; m_cnt = 0;
  endtask

  task automatic stepModel(input logic [3:0] r, input logic [3:0] d);
    if (!rst_n) begin
      resetModel();
      return;
    end
    m_timeout = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_busy) begin
      if (d[m_owner] || !r[m_owner] || m_cnt >= HOLD_MAX) begin
        m_timeout = !(d[m_owner] || !r[m_owner]);
        m_busy = 0;
        m_gap = 1;
        m_ptr = (m_owner + 1) % 4;
      end else begin
        m_cnt++;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!m_busy && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_busy = 1;
          m_cnt = 1;
        end
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".grant"}, 32'(grant), m_busy ? 32'(1 << m_owner) : 32'd0);
    checkOutput({tag, ".grant_idx"}, 32'(grant_idx), 32'(m_owner));
    checkOutput({tag, ".grant_valid"}, 32'(grant_valid), 32'(m_busy));
    checkOutput({tag, ".timeout"}, 32'(timeout), 32'(m_timeout));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d, input string tag);
    @(negedge clk);
    req = r;
    done = d;
    @(posedge clk);
    stepModel(r, d);
    #1;
    checkAll(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    resetModel();
    #1;
    checkAll("reset_async");
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b0000, "reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000, "reset_exit");
  endtask

  initial begin
    logic [3:0] rq;
    logic [3:0] dn;
    logic [3:0] seen[$];
    logic [3:0] rot_expect[5];
    logic       prev_valid;
    int         timeouts;

    resetModel();
    #1 rst_n = 1'b0;
    #1;
    checkAll("power_on_reset");
    doReset();
    checkOutput("reset.grant_const", 32'(grant), 32'd0);
    checkOutput("reset.idx_const", 32'(grant_idx), 32'd0);

    // Single requester with a done pulse; afterwards ptr=3 so 1000 wins next.
    applyStimulus(4'b0100, 4'b0000, "single");
    checkOutput("single.grant_const", 32'(grant), 32'b0100);
    checkOutput("single.idx_const", 32'(grant_idx), 32'd2);
    for (int i = 0; i < 2; i++) applyStimulus(4'b0100, 4'b0000, "single");
    applyStimulus(4'b0100, 4'b0100, "single_done");
    applyStimulus(4'b0100, 4'b0000, "single_gap");
    checkOutput("single.released", 32'(grant), 32'd0);
    applyStimulus(4'b1111, 4'b0000, "single_idle");
    applyStimulus(4'b1111, 4'b0000, "ptr_after_single");
    checkOutput("ptr_after_single.grant", 32'(grant), 32'b1000);

    // Rotation from ptr=0 with every requester active.
    doReset();
    rot_expect = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seen.delete();
    prev_valid = 1'b0;
    for (int i = 0; i < 60 && seen.size() < 5; i++) begin
      dn = (m_busy && m_cnt == 2) ? 4'(1 << m_owner) : 4'b0000;
      applyStimulus(4'b1111, dn, "rotation");
      if (grant_valid && !prev_valid) seen.push_back(grant);
      prev_valid = grant_valid;
    end
    checkOutput("rotation.count", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      checkOutput($sformatf("rotation.order%0d", i), 32'(seen[i]), 32'(rot_expect[i]));

    // Timeout: single holder, never releases.
    doReset();
    timeouts = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(4'b0001, 4'b0000, "timeout");
      if (timeout) timeouts++;
    end
    checkOutput("timeout.pulses", 32'(timeouts), 32'd2);

    // Non-owner done ignored; owner done on the timeout cycle is a release.
    doReset();
    applyStimulus(4'b0010, 4'b0000, "ignored");
    applyStimulus(4'b0010, 4'b0101, "ignored_done");
    checkOutput("ignored.grant", 32'(grant), 32'b0010);
    for (int i = 0; i < 12 && !(m_busy && m_cnt == HOLD_MAX); i++)
      applyStimulus(4'b0010, 4'b0000, "ignored_hold");
    applyStimulus(4'b0010, 4'b0010, "release_on_expiry");
    checkOutput("release_on_expiry.timeout", 32'(timeout), 32'd0);
    checkOutput("release_on_expiry.valid", 32'(grant_valid), 32'd0);

    // Reset asserted between edges while 1000 owns the resource.
    doReset();
    applyStimulus(4'b1000, 4'b0000, "midreset_setup");
    checkOutput("midreset.setup_grant", 32'(grant), 32'b1000);
    #2 rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("midreset.async_grant", 32'(grant), 32'd0);
    checkOutput("midreset.async_valid", 32'(grant_valid), 32'd0);
    applyStimulus(4'b1111, 4'b0000, "midreset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 4'b0000, "midreset_regrant");
    checkOutput("midreset.regrant", 32'(grant), 32'b0001);

    // Random traffic: sticky requests, occasional drops and sparse done pulses.
    doReset();
    rq = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (!rq[b] && $urandom_range(3) == 0) rq[b] = 1'b1;
        else if (rq[b] && $urandom_range(31) == 0) rq[b] = 1'b0;
      end
      dn = 4'b0000;
      for (int b = 0; b < 4; b++) if ($urandom_range(15) == 0) dn[b] = 1'b1;
      applyStimulus(rq, dn, "random");
      if (m_busy && !m_gap && grant_valid && dn[m_owner]) rq[m_owner] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
